qsub_serial: RTL

QSUB_SERIAL -- requirements
Module: qsub_serial

---
 rtl/qsub_serial_pkg.sv | 22 ++
 rtl/qsub_serial_if.sv | 39 +++
 rtl/qsub_serial_addsub_cell.sv | 31 +++
 rtl/qsub_serial.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/qsub_serial_pkg.sv
// Shared constants and types for the bit-serial sign-magnitude subtractor.
// The state enum is the single source of truth for the FSM encoding.
package qsub_serial_pkg;

   localparam int N_DEFAULT = 32;
   localparam int Q_DEFAULT = 15;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SERIAL = 2'd1,
      ST_NEGATE = 2'd2,
      ST_DONE   = 2'd3
   } qsub_state_e;

   // Bit counter must index the N-1 magnitude bits; keep at least one bit.
   function automatic int cnt_width(input int n);
      return (n > 2) ? $clog2(n - 1) : 1;
   endfunction

   localparam int CNT_W = cnt_width(N_DEFAULT);

endpackage

// File: rtl/qsub_serial_if.sv
// Operand/result bundle of qsub_serial. The requester drives i_start with operands;
// a start is accepted on any rising edge where the core is idle, and the result is
// valid whenever o_complete is high (it stays valid until the next accepted start).
interface qsub_serial_if #(
   parameter int N = 32
) ();

   logic [N-1:0] i_a;
   logic [N-1:0] i_b;
   logic         i_start;
   logic [N-1:0] o_c;
   logic         o_busy;
   logic         o_complete;
   logic         o_overflow;
   logic [1:0]   o_state;

   modport master (
      output i_a,
      output i_b,
      output i_start,
      input  o_c,
      input  o_busy,
      input  o_complete,
      input  o_overflow,
      input  o_state
   );

   modport slave (
      input  i_a,
      input  i_b,
      input  i_start,
      output o_c,
      output o_busy,
      output o_complete,
      output o_overflow,
      output o_state
   );

endinterface

// File: rtl/qsub_serial_addsub_cell.sv
// One-bit serial full adder / subtractor with its carry-or-borrow register.
// cb_next exposes the outgoing carry/borrow so the caller can see the final one.
module serial_addsub_cell (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic sub,
   input  logic x,
   input  logic y,
   output logic s,
   output logic cb_next
);

   logic cb;

   assign s = x ^ y ^ cb;

   // Borrow for x - y - cb, carry for x + y + cb.
   assign cb_next = sub ? ((~x & y) | (~(x ^ y) & cb))
                        : ((x & y) | (cb & (x ^ y)));

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cb <= 1'b0;
      end else if (en) begin
         cb <= cb_next;
      end
   end

endmodule

// File: rtl/qsub_serial.sv
// Bit-serial sign-magnitude subtractor c = a - b, one magnitude bit per cycle,
// with a serial two's-complement pass when the magnitude subtraction borrows.
module qsub_serial
   import qsub_serial_pkg::*;
#(
   parameter int Q = Q_DEFAULT,
   parameter int N = N_DEFAULT
) (
   input logic          i_clk,
   input logic          i_rst,
   qsub_serial_if.slave bus
);

   localparam int M  = N - 1;
   localparam int CW = cnt_width(N);

   localparam logic [1:0] S_IDLE   = 2'(ST_IDLE);
   localparam logic [1:0] S_SERIAL = 2'(ST_SERIAL);
   localparam logic [1:0] S_NEGATE = 2'(ST_NEGATE);
   localparam logic [1:0] S_DONE   = 2'(ST_DONE);

   localparam logic [CW-1:0] LAST = CW'(M - 1);

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [M-1:0]  sh_a;
   logic [M-1:0]  sh_b;
   logic [M-1:0]  sh_r;
   logic          sign_a;
   logic          sub_op;
   logic          neg;
   logic          ovf_r;
   logic [N-1:0]  c_q;
   logic          complete_q;
   logic          overflow_q;
   logic          res_sign;

   logic cell_en;
   logic cell_clr;
   logic cell_sub;
   logic cell_x;
   logic cell_y;
   logic cell_s;
   logic cell_cb_next;

   // Q only fixes where the binary point sits; the arithmetic ignores it.
   logic unused_q;
   assign unused_q = (Q >= 0);

   serial_addsub_cell u_cell (
      .clk     (i_clk),
      .rst     (i_rst),
      .clr     (cell_clr),
      .en      (cell_en),
      .sub     (cell_sub),
      .x       (cell_x),
      .y       (cell_y),
      .s       (cell_s),
      .cb_next (cell_cb_next)
   );

   // NEGATE reuses the cell as 0 - r with borrow; the borrow is cleared on the
   // last SERIAL cycle so the negate pass starts clean.
   always_comb begin
      cell_en  = 1'b0;
      cell_clr = 1'b0;
      cell_sub = sub_op;
      cell_x   = sh_a[0];
      cell_y   = sh_b[0];
      case (state)
         S_IDLE: begin
            cell_clr = bus.i_start;
         end
         S_SERIAL: begin
            cell_en  = 1'b1;
            cell_clr = (cnt == LAST);
         end
         S_NEGATE: begin
            cell_en  = 1'b1;
            cell_sub = 1'b1;
            cell_x   = 1'b0;
            cell_y   = sh_r[0];
         end
         default: begin
            cell_en = 1'b0;
         end
      endcase
   end

   // A zero magnitude never carries a negative sign.
   assign res_sign = (sh_r == '0) ? 1'b0 : (neg ? ~sign_a : sign_a);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         sh_a       <= '0;
         sh_b       <= '0;
         sh_r       <= '0;
         sign_a     <= 1'b0;
         sub_op     <= 1'b0;
         neg        <= 1'b0;
         ovf_r      <= 1'b0;
         c_q        <= '0;
         complete_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.i_start) begin
                  sh_a       <= bus.i_a[M-1:0];
                  sh_b       <= bus.i_b[M-1:0];
                  sign_a     <= bus.i_a[N-1];
                  sub_op     <= (bus.i_a[N-1] == bus.i_b[N-1]);
                  neg        <= 1'b0;
                  ovf_r      <= 1'b0;
                  cnt        <= '0;
                  complete_q <= 1'b0;
                  overflow_q <= 1'b0;
                  state      <= S_SERIAL;
               end
            end
            S_SERIAL: begin
               sh_a <= sh_a >> 1;
               sh_b <= sh_b >> 1;
               sh_r <= {cell_s, sh_r[M-1:1]};
               cnt  <= cnt + 1'b1;
               if (cnt == LAST) begin
                  cnt <= '0;
                  if (!sub_op) begin
                     ovf_r <= cell_cb_next;
                     state <= S_DONE;
                  end else if (cell_cb_next) begin
                     neg   <= 1'b1;
                     state <= S_NEGATE;
                  end else begin
                     state <= S_DONE;
                  end
               end
            end
            S_NEGATE: begin
               sh_r <= {cell_s, sh_r[M-1:1]};
               cnt  <= cnt + 1'b1;
               if (cnt == LAST) begin
                  cnt   <= '0;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               c_q        <= {res_sign, sh_r};
               complete_q <= 1'b1;
               overflow_q <= ovf_r;
               state      <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.o_c        = c_q;
   assign bus.o_busy     = (state == S_SERIAL) || (state == S_NEGATE);
   assign bus.o_complete = complete_q;
   assign bus.o_overflow = overflow_q;
   assign bus.o_state    = state;

endmodule
